// File: rtl/pixel_rx_pkg.sv
// Shared constants, serializer state type and a width helper for the pixel readout receiver.
// Optional checksum beat is selected with the PIXEL_RX_CHECKSUM_EN macro.
package pixel_rx_pkg;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_N_COLS     = 2;
    localparam int DEF_N_ROWS     = 2;
    localparam int DEF_FIFO_DEPTH = 4;

`ifdef PIXEL_RX_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef PIXEL_RX_CHECKSUM_EN
        ST_CHK   = 2'd2,
`endif
        ST_SHIFT = 2'd1
    } ser_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pixel_row_fifo.sv
// Synchronous row FIFO with registered head word and full/empty flags.
// A flush takes effect before any push in the same cycle, so that push becomes the only entry.
module pixel_row_fifo
    import pixel_rx_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = idx_w(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_base_s, rd_base_s;
    logic [CW-1:0]    count_q, count_d, count_base_s;
    logic [WIDTH-1:0] head_q, head_d;
    logic             full_q, empty_q, do_push_s, do_pop_s;

    // Next pointers, occupancy and head word; a full FIFO accepts a push only alongside a pop.
    always_comb begin
        if (flush_i) begin
            wr_base_s    = {AW{1'b0}};
            rd_base_s    = {AW{1'b0}};
            count_base_s = {CW{1'b0}};
        end else begin
            wr_base_s    = wr_ptr_q;
            rd_base_s    = rd_ptr_q;
            count_base_s = count_q;
        end
        do_pop_s  = pop_i && !flush_i && !empty_q;
        do_push_s = push_i && ((count_base_s != CW'(DEPTH)) || do_pop_s);
        rd_ptr_d  = rd_base_s + AW'(do_pop_s);
        wr_ptr_d  = wr_base_s + AW'(do_push_s);
        count_d   = count_base_s + CW'(do_push_s) - CW'(do_pop_s);
        if (do_push_s && (wr_base_s == rd_ptr_d)) begin
            head_d = wr_data_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_base_s] <= wr_data_i;
        end
    end

    // Pointer, count, head and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            head_q   <= {WIDTH{1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            full_q   <= (count_d == CW'(DEPTH));
            empty_q  <= (count_d == {CW{1'b0}});
        end
    end

    assign rd_data_o = head_q;
    assign full_o    = full_q;
    assign empty_o   = empty_q;
endmodule

// File: rtl/pixel_readout_rx.sv
// Pixel readout receiver: buffers row words and serializes them into framed pixel beats.
// Define PIXEL_RX_CHECKSUM_EN to append a checksum beat after the last pixel of each frame.
module pixel_readout_rx
    import pixel_rx_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int N_COLS     = DEF_N_COLS,
    parameter int N_ROWS     = DEF_N_ROWS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_start,
    input  logic                     read_strobe,
    input  logic [N_COLS*DATA_W-1:0] row_data,
    input  logic                     pix_ready,
    output logic                     pix_valid,
    output logic [DATA_W-1:0]        pix_data,
    output logic                     pix_sof,
    output logic                     pix_eol,
    output logic                     pix_eof,
    output logic                     pix_chk,
    output logic                     overflow,
    output logic [15:0]              frame_cnt
);
    localparam int RW = idx_w(N_ROWS);
    localparam int CW = idx_w(N_COLS);
    localparam int WW = N_COLS * DATA_W;

    ser_state_e        state_q, state_d;
    logic [WW-1:0]     sh_q, sh_d, fifo_head_s;
    logic [CW-1:0]     col_q, col_d, col_nx_s;
    logic [RW-1:0]     row_q, row_d, rcnt_q, rcnt_d;
    logic [DATA_W-1:0] cks_q, cks_d;
    logic [15:0]       fcnt_q, fcnt_d;
    logic              valid_q, valid_d, sof_q, sof_d, eol_q, eol_d;
    logic              eof_q, eof_d, chk_q, chk_d, ovf_q, ovf_d;
    logic              fifo_full_s, fifo_empty_s, pop_s, beat_s, load_s, idle_s;
    logic              last_col_s, last_row_s;

    pixel_row_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush_i   (frame_start),
        .push_i    (read_strobe),
        .wr_data_i (row_data),
        .pop_i     (pop_s),
        .rd_data_o (fifo_head_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s)
    );

    // Serializer next state; frame_start wins over everything except reset.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        col_d   = col_q;
        row_d   = row_q;
        rcnt_d  = rcnt_q;
        cks_d   = cks_q;
        valid_d = valid_q;
        sof_d   = sof_q;
        eol_d   = eol_q;
        eof_d   = eof_q;
        chk_d   = chk_q;
        fcnt_d  = fcnt_q;
        load_s  = 1'b0;
        idle_s  = 1'b0;
        beat_s     = valid_q && pix_ready;
        last_col_s = (col_q == CW'(N_COLS - 1));
        last_row_s = (row_q == RW'(N_ROWS - 1));
        col_nx_s   = col_q + CW'(1);
        if (beat_s && eof_q) begin
            fcnt_d = fcnt_q + 16'd1;
        end else begin
            fcnt_d = fcnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                load_s = !fifo_empty_s;
            end
            ST_SHIFT: begin
                if (beat_s) begin
                    // sof restarts the running frame sum
                    cks_d = (sof_q ? {DATA_W{1'b0}} : cks_q) + sh_q[DATA_W-1:0];
                    if (!last_col_s) begin
                        sh_d  = sh_q >> DATA_W;
                        col_d = col_nx_s;
                        sof_d = 1'b0;
                        eol_d = (col_nx_s == CW'(N_COLS - 1));
                        eof_d = !CHK_EN && (col_nx_s == CW'(N_COLS - 1)) && last_row_s;
                    end
`ifdef PIXEL_RX_CHECKSUM_EN
                    else if (last_row_s) begin
                        state_d           = ST_CHK;
                        sh_d              = {WW{1'b0}};
                        sh_d[DATA_W-1:0]  = cks_d;
                        sof_d             = 1'b0;
                        eol_d             = 1'b0;
                        eof_d             = 1'b1;
                        chk_d             = 1'b1;
                    end
`endif
                    else if (!fifo_empty_s) begin
                        load_s = 1'b1;
                    end else begin
                        idle_s = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
`ifdef PIXEL_RX_CHECKSUM_EN
            ST_CHK: begin
                if (beat_s) begin
                    load_s = !fifo_empty_s;
                    idle_s = fifo_empty_s;
                end else begin
                    state_d = state_q;
                end
            end
`endif
            default: idle_s = 1'b1;
        endcase

        if (load_s) begin
            state_d = ST_SHIFT;
            sh_d    = fifo_head_s;
            col_d   = {CW{1'b0}};
            row_d   = rcnt_q;
            rcnt_d  = (rcnt_q == RW'(N_ROWS - 1)) ? {RW{1'b0}} : rcnt_q + RW'(1);
            valid_d = 1'b1;
            sof_d   = (rcnt_q == {RW{1'b0}});
            eol_d   = (N_COLS == 1);
            eof_d   = !CHK_EN && (N_COLS == 1) && (rcnt_q == RW'(N_ROWS - 1));
            chk_d   = 1'b0;
        end else if (idle_s) begin
            state_d = ST_IDLE;
            sh_d    = {WW{1'b0}};
            valid_d = 1'b0;
            sof_d   = 1'b0;
            eol_d   = 1'b0;
            eof_d   = 1'b0;
            chk_d   = 1'b0;
        end else begin
            state_d = state_d;
        end

        if (frame_start) begin
            state_d = ST_IDLE;
            sh_d    = {WW{1'b0}};
            rcnt_d  = {RW{1'b0}};
            cks_d   = {DATA_W{1'b0}};
            valid_d = 1'b0;
            sof_d   = 1'b0;
            eol_d   = 1'b0;
            eof_d   = 1'b0;
            chk_d   = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            ovf_d   = ovf_q || (read_strobe && fifo_full_s && !load_s);
        end
        pop_s = load_s && !frame_start;
    end

    // Serializer and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sh_q    <= {WW{1'b0}};
            col_q   <= {CW{1'b0}};
            row_q   <= {RW{1'b0}};
            rcnt_q  <= {RW{1'b0}};
            cks_q   <= {DATA_W{1'b0}};
            fcnt_q  <= 16'd0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            chk_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            col_q   <= col_d;
            row_q   <= row_d;
            rcnt_q  <= rcnt_d;
            cks_q   <= cks_d;
            fcnt_q  <= fcnt_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
            chk_q   <= chk_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pix_valid = valid_q;
    assign pix_data  = sh_q[DATA_W-1:0];
    assign pix_sof   = sof_q;
    assign pix_eol   = eol_q;
    assign pix_eof   = eof_q;
    assign pix_chk   = chk_q;
    assign overflow  = ovf_q;
    assign frame_cnt = fcnt_q;
endmodule

// File: tb/tb_pixel_readout_rx.sv
// Self-checking bench for pixel_readout_rx: directed frame scenarios plus randomized traffic
// compared against a beat-list reference model. Honours PIXEL_RX_CHECKSUM_EN.
module tb_pixel_readout_rx;
    localparam int DATA_W     = 8;
    localparam int N_COLS     = 2;
    localparam int N_ROWS     = 2;
    localparam int FIFO_DEPTH = 4;
`ifdef PIXEL_RX_CHECKSUM_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    // flags = {sof, eol, eof, chk}
    typedef struct {
        logic [7:0] data;
        logic [3:0] flags;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset, frame_start, read_strobe, pix_ready;
    logic [15:0] row_data;
    logic        pix_valid, pix_sof, pix_eol, pix_eof, pix_chk, overflow;
    logic [7:0]  pix_data;
    logic [15:0] frame_cnt;

    int          n_cmp = 0;
    int          n_err = 0;
    beat_t       exp_q[$];
    logic [7:0]  seen_q[$];
    int          model_row, model_sum, exp_fcnt;
    bit          exp_ovf;
    logic        prev_valid, prev_ready, prev_fs;
    logic [11:0] prev_out;

    pixel_readout_rx #(
        .DATA_W     (DATA_W),
        .N_COLS     (N_COLS),
        .N_ROWS     (N_ROWS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .read_strobe (read_strobe),
        .row_data    (row_data),
        .pix_ready   (pix_ready),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_sof     (pix_sof),
        .pix_eol     (pix_eol),
        .pix_eof     (pix_eof),
        .pix_chk     (pix_chk),
        .overflow    (overflow),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_flush();
        exp_q.delete();
        model_row = 0;
        model_sum = 0;
        exp_ovf   = 1'b0;
    endtask

    // A row expands into N_COLS pixel beats, plus a checksum beat after the last row when enabled.
    task automatic model_push(input logic [15:0] row);
        beat_t b;
        for (int c = 0; c < N_COLS; c++) begin
            b.data = row[c*DATA_W +: DATA_W];
            model_sum = (model_row == 0 && c == 0) ? int'(b.data) : (model_sum + int'(b.data)) % 256;
            b.flags[3] = (model_row == 0 && c == 0);
            b.flags[2] = (c == N_COLS - 1);
            b.flags[1] = !CHK_ON && (c == N_COLS - 1) && (model_row == N_ROWS - 1);
            b.flags[0] = 1'b0;
            exp_q.push_back(b);
        end
        if (CHK_ON && model_row == N_ROWS - 1) begin
            b.data  = 8'(model_sum);
            b.flags = 4'b0011;
            exp_q.push_back(b);
        end
        model_row = (model_row + 1) % N_ROWS;
    endtask

    function automatic int rows_pending();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i].flags[2]) n++;
        return n;
    endfunction

    task automatic monitor();
        beat_t b;
        check_eq("frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
        check_eq("overflow", 32'(overflow), 32'(exp_ovf));
        if (prev_valid && !prev_ready && !prev_fs) begin
            check_eq("hold_valid", 32'(pix_valid), 32'd1);
            check_eq("hold_beat", 32'({pix_data, pix_sof, pix_eol, pix_eof, pix_chk}), 32'(prev_out));
        end
        if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_beat", 32'(pix_valid), 32'd0);
            end else begin
                b = exp_q.pop_front();
                check_eq("beat_data", 32'(pix_data), 32'(b.data));
                check_eq("beat_flags", 32'({pix_sof, pix_eol, pix_eof, pix_chk}), 32'(b.flags));
                if (b.flags[1]) exp_fcnt = (exp_fcnt + 1) % 65536;
            end
            seen_q.push_back(pix_data);
        end
        prev_valid = pix_valid;
        prev_ready = pix_ready;
        prev_out   = {pix_data, pix_sof, pix_eol, pix_eof, pix_chk};
    endtask

    // One clock: check outputs with the inputs already applied, update the model, advance to the next negedge.
    task automatic tick(input bit accept);
        if (reset) begin
            model_flush();
            exp_fcnt   = 0;
            prev_valid = 1'b0;
        end else begin
            monitor();
            if (frame_start) model_flush();
            if (read_strobe) begin
                if (accept) model_push(row_data);
                else exp_ovf = 1'b1;
            end
        end
        prev_fs = frame_start || reset;
        @(posedge clk);
        @(negedge clk);
        frame_start = 1'b0;
        read_strobe = 1'b0;
    endtask

    task automatic strobe(input logic [15:0] row, input bit accept);
        read_strobe = 1'b1;
        row_data    = row;
        tick(accept);
    endtask

    task automatic drain(input int max_ticks);
        int n = 0;
        pix_ready = 1'b1;
        while ((exp_q.size() != 0 || pix_valid) && n < max_ticks) begin
            tick(1'b1);
            n++;
        end
        check_eq("drain_queue", 32'(exp_q.size()), 32'd0);
        check_eq("drain_valid", 32'(pix_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(pix_valid), 32'd0);
        check_eq({tag, "_data"}, 32'(pix_data), 32'd0);
        check_eq({tag, "_flags"}, 32'({pix_sof, pix_eol, pix_eof, pix_chk}), 32'd0);
        check_eq({tag, "_ovf"}, 32'(overflow), 32'd0);
        check_eq({tag, "_fcnt"}, 32'(frame_cnt), 32'd0);
    endtask

    task automatic check_basic_frame(input string tag);
        logic [7:0] want [5];
        want = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
        check_eq({tag, "_count"}, 32'(seen_q.size()), CHK_ON ? 32'd5 : 32'd4);
        for (int i = 0; i < (CHK_ON ? 5 : 4); i++) begin
            check_eq({tag, "_seq"}, 32'(seen_q[i]), 32'(want[i]));
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; frame_start = 1'b0; read_strobe = 1'b0; pix_ready = 1'b0; row_data = 16'h0;
        model_flush();
        exp_fcnt = 0; prev_valid = 1'b0; prev_ready = 1'b0; prev_fs = 1'b1; prev_out = 12'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Basic frame, checking first-beat latency
        frame_start = 1'b1; pix_ready = 1'b1; tick(1'b1);
        seen_q.delete();
        strobe(16'h2211, 1'b1);
        check_eq("latency_t1", 32'(pix_valid), 32'd0);
        strobe(16'h4433, 1'b1);
        check_eq("latency_t2", 32'(pix_valid), 32'd1);
        check_eq("first_data", 32'(pix_data), 32'h11);
        drain(40);
        check_basic_frame("frame1");
        check_eq("frame_cnt_1", 32'(frame_cnt), 32'd1);

        // Backpressure on the first beat
        frame_start = 1'b1; pix_ready = 1'b0; tick(1'b1);
        seen_q.delete();
        strobe(16'h2211, 1'b1);
        strobe(16'h4433, 1'b1);
        repeat (5) begin
            tick(1'b1);
            check_eq("stall_data", 32'(pix_data), 32'h11);
        end
        drain(40);
        check_basic_frame("stall");

        // Overflow: one row in the serializer, four queued, fifth dropped
        frame_start = 1'b1; pix_ready = 1'b0; tick(1'b1);
        strobe(16'($urandom), 1'b1);
        repeat (3) tick(1'b1);
        repeat (4) strobe(16'($urandom), 1'b1);
        check_eq("ovf_before", 32'(overflow), 32'd0);
        strobe(16'($urandom), 1'b0);
        check_eq("ovf_set", 32'(overflow), 32'd1);
        repeat (3) tick(1'b1);
        drain(60);
        check_eq("ovf_sticky", 32'(overflow), 32'd1);
        frame_start = 1'b1; tick(1'b1);
        check_eq("ovf_cleared", 32'(overflow), 32'd0);

        // frame_start during the second beat of a row
        pix_ready = 1'b1;
        strobe(16'($urandom), 1'b1);
        strobe(16'($urandom), 1'b1);
        strobe(16'($urandom), 1'b1);
        n = 0;
        while (!(pix_valid && pix_eol) && n < 10) begin
            tick(1'b1);
            n++;
        end
        check_eq("wait_eol", 32'(pix_eol), 32'd1);
        frame_start = 1'b1; tick(1'b1);
        check_eq("fs_valid_drop", 32'(pix_valid), 32'd0);
        check_eq("fs_ovf", 32'(overflow), 32'd0);
        tick(1'b1); tick(1'b1);
        check_eq("fs_fifo_empty", 32'(pix_valid), 32'd0);
        strobe(16'h6655, 1'b1);
        tick(1'b1);
        check_eq("fs_next_sof", 32'({pix_valid, pix_sof, pix_data}), 32'h355);
        drain(40);

        // Reset mid-frame overriding frame_start and read_strobe
        frame_start = 1'b1; pix_ready = 1'b0; tick(1'b1);
        repeat (3) strobe(16'($urandom), 1'b1);
        reset = 1'b1; frame_start = 1'b1; read_strobe = 1'b1; row_data = 16'hBEEF;
        tick(1'b1);
        check_reset_outputs("midreset");
        reset = 1'b0;
        tick(1'b1);
        check_eq("post_reset_idle", 32'(pix_valid), 32'd0);
        pix_ready = 1'b1;
        strobe(16'h0201, 1'b1);
        strobe(16'h0403, 1'b1);
        drain(40);

        // Randomized traffic, throttled so the FIFO can never overflow
        for (int i = 0; i < 400; i++) begin
            pix_ready = ($urandom % 4) != 0;
            if ($urandom % 50 == 0) frame_start = 1'b1;
            if (rows_pending() < FIFO_DEPTH && ($urandom % 3) == 0) begin
                read_strobe = 1'b1;
                row_data    = 16'($urandom);
            end
            tick(1'b1);
        end
        drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
